// File: rtl/aha_tlx_pkg.sv
// Shared TLX training-lane definitions: state encoding and default widths.
// The forward output lane uses the same package.
package aha_tlx_pkg;

  localparam int unsigned SEQ_W_DEF  = 32;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned HUNT_CNT_W = 16;

  typedef enum logic [1:0] {
    TLX_IDLE  = 2'd0,
    TLX_HUNT  = 2'd1,
    TLX_CHECK = 2'd2
  } tlx_state_e;

endpackage

// File: rtl/aha_tlx_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module aha_tlx_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/aha_tlx_train_rx_lane.sv
// TLX reverse-channel training receiver lane: hunts a serial stream for the
// programmed training word, then locks and scores each following word.
module aha_tlx_train_rx_lane
  import aha_tlx_pkg::*;
#(
  parameter int unsigned SEQ_W      = SEQ_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned HUNT_LIMIT = 96
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             D_IN,
  input  logic             START,
  input  logic             CLEAR,
  input  logic [SEQ_W-1:0] SEQUENCE,
  input  logic [31:0]      LENGTH,
  input  logic             AUTO_STOP,
  output logic             DONE,
  output logic             ACTIVE,
  output logic             LOCKED,
  output logic [CNT_W-1:0] MATCH_COUNT,
  output logic [CNT_W-1:0] ERR_COUNT
);

  localparam int unsigned BIT_W = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
  localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(SEQ_W - 1);
  localparam logic [HUNT_CNT_W-1:0] HUNT_MIN  = HUNT_CNT_W'(SEQ_W - 1);
  localparam logic [HUNT_CNT_W-1:0] HUNT_LAST = HUNT_CNT_W'(HUNT_LIMIT - 1);

  tlx_state_e            state_q, state_d;
  logic [SEQ_W-1:0]      sr_q, sr_d, seq_q, seq_d;
  logic [31:0]           len_q, len_d;
  logic [HUNT_CNT_W-1:0] hunt_q, hunt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  done_q, done_d, locked_q, locked_d, active_q, active_d;

  logic             clr_cnt, inc_match, inc_err, inc_word;
  logic             hit, reached;
  logic [CNT_W-1:0] word_cnt, word_inc;

  assign sr_d     = {sr_q[SEQ_W-2:0], D_IN};
  assign hit      = (sr_d == seq_q);
  assign word_inc = (word_cnt == '1) ? word_cnt : word_cnt + CNT_W'(1);
  // word_cnt is 0 throughout HUNT, so the same test covers a LENGTH=1 lock word.
  assign reached  = (len_q != '0) && (CMP_W'(word_inc) == CMP_W'(len_q));

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    len_d     = len_q;
    hunt_d    = hunt_q;
    bit_d     = bit_q;
    done_d    = done_q;
    locked_d  = locked_q;
    clr_cnt   = 1'b0;
    inc_match = 1'b0;
    inc_err   = 1'b0;
    inc_word  = 1'b0;

    if (CLEAR) begin
      state_d  = TLX_IDLE;
      done_d   = 1'b0;
      locked_d = 1'b0;
      clr_cnt  = 1'b1;
    end else if (START) begin
      state_d  = TLX_HUNT;
      seq_d    = SEQUENCE;
      len_d    = LENGTH;
      hunt_d   = '0;
      done_d   = 1'b0;
      locked_d = 1'b0;
      clr_cnt  = 1'b1;
    end else begin
      unique case (state_q)
        TLX_HUNT: begin
          hunt_d = hunt_q + HUNT_CNT_W'(1);
          if ((hunt_q >= HUNT_MIN) && hit) begin
            state_d   = TLX_CHECK;
            locked_d  = 1'b1;
            inc_match = 1'b1;
            inc_word  = 1'b1;
            bit_d     = '0;
            if (reached) begin
              done_d = 1'b1;
              if (AUTO_STOP) state_d = TLX_IDLE;
            end
          end else if (hunt_q == HUNT_LAST) begin
            state_d  = TLX_IDLE;
            done_d   = 1'b1;
            locked_d = 1'b0;
          end
        end
        TLX_CHECK: begin
          bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            inc_word  = 1'b1;
            inc_match = hit;
            inc_err   = !hit;
            if (reached) begin
              done_d = 1'b1;
              if (AUTO_STOP) state_d = TLX_IDLE;
            end
          end
        end
        default: ;
      endcase
    end

    active_d = (state_d != TLX_IDLE);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= TLX_IDLE;
      sr_q     <= '0;
      seq_q    <= '0;
      len_q    <= '0;
      hunt_q   <= '0;
      bit_q    <= '0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      seq_q    <= seq_d;
      len_q    <= len_d;
      hunt_q   <= hunt_d;
      bit_q    <= bit_d;
      done_q   <= done_d;
      locked_q <= locked_d;
      active_q <= active_d;
    end
  end

  aha_tlx_sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk(CLK), .rst_n(RESETn), .clear(clr_cnt), .inc(inc_match), .count(MATCH_COUNT)
  );

  aha_tlx_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(CLK), .rst_n(RESETn), .clear(clr_cnt), .inc(inc_err), .count(ERR_COUNT)
  );

  aha_tlx_sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk(CLK), .rst_n(RESETn), .clear(clr_cnt), .inc(inc_word), .count(word_cnt)
  );

  assign DONE   = done_q;
  assign ACTIVE = active_q;
  assign LOCKED = locked_q;

endmodule
